// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit path and the future receive path.
// Contents:
//   UART_DATA_BITS, UART_OVERSAMPLE - default frame geometry
//   uart_state_t and St* constants  - transmitter FSM encoding
package uart_pkg;

    localparam int unsigned UART_DATA_BITS  = 8;
    localparam int unsigned UART_OVERSAMPLE = 16;

    typedef logic [1:0] uart_state_t;

    localparam uart_state_t StIdle  = 2'd0;
    localparam uart_state_t StStart = 2'd1;
    localparam uart_state_t StData  = 2'd2;
    localparam uart_state_t StStop  = 2'd3;

endpackage

// File: rtl/cdc_sync_bit.sv
// Multi-stage single-bit synchroniser with asynchronous active-high reset to 0.
// Ports:
//   clk_i  destination clock
//   rst_i  asynchronous reset, active high
//   d_i    asynchronous input bit
//   q_o    synchronised output (SYNC_STAGES cycles of latency)
module cdc_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_tx_toggle.sv
// Toggle-handshake UART transmitter (8N1 by default).
// A change of local_st relative to remote_st requests one frame carrying data;
// remote_st is set to the request value once the stop bit(s) are finished.
// Ports:
//   clk_uart16  16x baud clock, the only clock
//   rst         asynchronous reset, active high
//   data        payload, stable from the writer until completion
//   local_st    request toggle from the register block (asynchronous)
//   remote_st   completion toggle
//   busy        high while a frame is in progress
//   tx          serial line, idle high, driven from a flop
module uart_tx_toggle
    import uart_pkg::*;
#(
    parameter int unsigned DATA_BITS   = UART_DATA_BITS,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned OVERSAMPLE  = UART_OVERSAMPLE,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                 clk_uart16,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data,
    input  logic                 local_st,
    output logic                 remote_st,
    output logic                 busy,
    output logic                 tx
);

    localparam int unsigned StopTicks = OVERSAMPLE * STOP_BITS;
    localparam int unsigned TickW     = (StopTicks > 1) ? $clog2(StopTicks) : 1;
    localparam int unsigned BitW      = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

    localparam logic [TickW-1:0] BitEnd  = TickW'(OVERSAMPLE - 1);
    localparam logic [TickW-1:0] StopEnd = TickW'(StopTicks - 1);
    localparam logic [BitW-1:0]  LastBit = BitW'(DATA_BITS - 1);

    uart_state_t          state_q, state_d;
    logic [TickW-1:0]     tick_q, tick_d;
    logic [BitW-1:0]      bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 req_lat_q, req_lat_d;
    logic                 remote_q, remote_d;
    logic                 busy_q, busy_d;
    logic                 tx_q, tx_d;
    logic                 req_s;

    cdc_sync_bit #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk_i (clk_uart16),
        .rst_i (rst),
        .d_i   (local_st),
        .q_o   (req_s)
    );

    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        req_lat_d = req_lat_q;
        remote_d  = remote_q;

        unique case (state_q)
            StIdle: begin
                // data has been stable for SYNC_STAGES cycles by the time req_s moves
                if (req_s != remote_q) begin
                    shift_d   = data;
                    req_lat_d = req_s;
                    tick_d    = '0;
                    state_d   = StStart;
                end
            end
            StStart: begin
                if (tick_q == BitEnd) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = StData;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StData: begin
                if (tick_q == BitEnd) begin
                    tick_d  = '0;
                    shift_d = shift_q >> 1;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LastBit) begin
                        state_d = StStop;
                    end
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            StStop: begin
                if (tick_q == StopEnd) begin
                    tick_d   = '0;
                    remote_d = req_lat_q;
                    state_d  = StIdle;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs are registered from the next state so tx and busy switch on the
    // same edge as the state they describe.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            StStart: tx_d = 1'b0;
            StData:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk_uart16 or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            req_lat_q <= 1'b0;
            remote_q  <= 1'b0;
            busy_q    <= 1'b0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            req_lat_q <= req_lat_d;
            remote_q  <= remote_d;
            busy_q    <= busy_d;
            tx_q      <= tx_d;
        end
    end

    assign remote_st = remote_q;
    assign busy      = busy_q;
    assign tx        = tx_q;

endmodule

// File: tb/tb_uart_tx_toggle.sv
// Self-checking bench for uart_tx_toggle: stimulus pushes expected frames
// (payload, start cycle, request value) into a queue; a monitor decodes tx and
// compares each frame it sees. A second instance covers the two-stop-bit build.
`timescale 1ns/1ps
module tb_uart_tx_toggle;

    localparam int OS     = 16;
    localparam int SYNC   = 2;
    localparam int FRAME  = 10 * OS;
    localparam int FRAME2 = 11 * OS;

    typedef struct {
        logic [7:0] d;
        int         start;
        logic       req;
    } exp_t;

    exp_t exp_q[$];

    logic       clk_uart16 = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       local_st;
    logic       remote_st, busy, tx;
    logic [7:0] data2;
    logic       local_st2;
    logic       remote_st2, busy2, tx2;

    int cycle     = 0;
    int errors    = 0;
    int checks    = 0;
    int model_end = 0;
    int last_start = 0;

    bit         in_frame = 1'b0;
    bit         cur_valid = 1'b0;
    int         fstart;
    int         mon_off;
    exp_t       cur;
    logic [9:0] got;

    uart_tx_toggle u_dut (
        .clk_uart16 (clk_uart16),
        .rst        (rst),
        .data       (data),
        .local_st   (local_st),
        .remote_st  (remote_st),
        .busy       (busy),
        .tx         (tx)
    );

    uart_tx_toggle #(
        .STOP_BITS (2)
    ) u_dut2 (
        .clk_uart16 (clk_uart16),
        .rst        (rst),
        .data       (data2),
        .local_st   (local_st2),
        .remote_st  (remote_st2),
        .busy       (busy2),
        .tx         (tx2)
    );

    always #5 clk_uart16 = ~clk_uart16;

    always @(posedge clk_uart16) cycle <= cycle + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    // Monitor: decode every frame on tx and compare with the queue head.
    always @(negedge clk_uart16) begin
        if (rst) begin
            in_frame = 1'b0;
        end else if (!in_frame) begin
            if (tx === 1'b0) begin
                in_frame = 1'b1;
                fstart   = cycle;
                got      = '0;
                check("busy_at_start", busy, 1);
                check("frame_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    cur       = exp_q.pop_front();
                    cur_valid = 1'b1;
                    check("start_cycle", cycle, cur.start);
                end else begin
                    cur_valid = 1'b0;
                end
            end
        end else begin
            mon_off = cycle - fstart;
            if ((mon_off % OS) == OS / 2 && mon_off < FRAME) got[mon_off / OS] = tx;
            if (mon_off == FRAME - 1) begin
                check("busy_last_stop", busy, 1);
                if (cur_valid) check("remote_before_end", remote_st, !cur.req);
            end
            if (mon_off == FRAME) begin
                check("busy_after_frame", busy, 0);
                if (cur_valid) begin
                    check("frame_bits", got, {1'b1, cur.d, 1'b0});
                    check("remote_after_end", remote_st, cur.req);
                end
                in_frame = 1'b0;
            end
        end
    end

    // Call only from a point #1 after a rising edge.
    task automatic tick_to(input int n);
        while (cycle < n) begin
            @(posedge clk_uart16);
            #1;
        end
    endtask

    // Reference: a request seen by the idle transmitter starts SYNC+1 cycles
    // after the toggle, but never before one idle cycle after the previous frame.
    task automatic send(input logic [7:0] d);
        exp_t e;
        data     = d;
        local_st = ~local_st;
        e.d      = d;
        e.req    = local_st;
        e.start  = (cycle + SYNC + 1 > model_end + 1) ? cycle + SYNC + 1 : model_end + 1;
        exp_q.push_back(e);
        model_end  = e.start + FRAME;
        last_start = e.start;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        int   s;
        int   k;
        int   t_fall;
        int   t_rem;
        int   off;
        logic [10:0] bits2;

        rst       = 1'b0;
        data      = '0;
        local_st  = 1'b0;
        data2     = '0;
        local_st2 = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_remote", remote_st, 0);
        check("rst_tx2", tx2, 1);
        repeat (3) @(posedge clk_uart16);
        #1 rst = 1'b0;

        // Single frame, alternating payload.
        tick_to(cycle + 2);
        send(8'h55);
        tick_to(model_end + 1);

        // Back-to-back all-zeros then all-ones.
        send(8'h00);
        tick_to(last_start);
        send(8'hFF);
        tick_to(model_end + 1);
        check("remote_eq_local_a", remote_st, local_st);

        // Second request and data change arrive 50 cycles into a frame.
        send(8'hA5);
        tick_to(last_start + 50);
        send(8'h3C);
        tick_to(model_end + 1);
        check("remote_eq_local_b", remote_st, local_st);

        // Double toggle mid-frame cancels out: no extra frame.
        send(8'h12);
        s = last_start;
        tick_to(s + 20);
        local_st = ~local_st;
        data     = 8'h77;
        tick_to(s + 40);
        local_st = ~local_st;
        tick_to(model_end + 40);
        check("remote_eq_local_c", remote_st, local_st);
        check("idle_after_double", tx, 1);

        // Random payloads and random request timing.
        for (int i = 0; i < 5; i++) begin
            tick_to(last_start + $urandom_range(0, 200));
            send(8'($urandom));
        end
        tick_to(model_end + 1);
        check("remote_eq_local_d", remote_st, local_st);

        // Reset 70 cycles into a frame.
        send(8'h00);
        s = last_start;
        tick_to(s + 70);
        check("pre_rst_tx", tx, 0);
        check("pre_rst_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("async_rst_tx", tx, 1);
        check("async_rst_busy", busy, 0);
        check("async_rst_remote", remote_st, 0);
        local_st = 1'b1;
        data     = 8'($urandom);
        repeat (2) @(posedge clk_uart16);
        #1 rst = 1'b0;
        e.d   = data;
        e.req = 1'b1;
        e.start = cycle + SYNC + 1;
        exp_q.push_back(e);
        last_start = e.start;
        model_end  = e.start + FRAME;
        tick_to(model_end + 1);
        check("remote_after_rst_frame", remote_st, 1);

        // Two-stop-bit build.
        tick_to(cycle + 2);
        data2     = 8'h81;
        local_st2 = 1'b1;
        k         = cycle;
        t_fall    = -1;
        for (int i = 0; i < 20 && t_fall < 0; i++) begin
            @(negedge clk_uart16);
            if (tx2 === 1'b0) t_fall = cycle;
        end
        check("s2_latency", t_fall, k + SYNC + 1);
        if (t_fall >= 0) begin
            t_rem = -1;
            bits2 = '0;
            for (int i = 0; i < 400 && t_rem < 0; i++) begin
                @(negedge clk_uart16);
                off = cycle - t_fall;
                if ((off % OS) == OS / 2 && off < FRAME2) bits2[off / OS] = tx2;
                if (off == FRAME2 - 1) begin
                    check("s2_busy_last", busy2, 1);
                    check("s2_stop_tail", tx2, 1);
                end
                if (remote_st2 === 1'b1) t_rem = cycle;
            end
            check("s2_frame_len", t_rem - t_fall, FRAME2);
            check("s2_bits", bits2, {2'b11, 8'h81, 1'b0});
            check("s2_busy_after", busy2, 0);
        end

        tick_to(model_end + 5);
        check("queue_drained", exp_q.size(), 0);
        check("monitor_idle", in_frame, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
